fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//   Sequences the word-addressed instruction memory (program_counter -> instruction, combinational read).
//   Drives the memory address and registers the returned word into a one-entry output stage toward decode.
//   Output stage uses a valid/ready handshake. Handles start, branch redirect, back-pressure and
//   end-of-program halt. Counts delivered instructions.
// PARAMETERS
//   ADDR_W   32   width of PC / memory word index
//   DATA_W   32   instruction width
//   LAST_PC  6    index of last valid instruction; fetch stops after it
//   CNT_W    16   width of delivered-instruction counter (saturating)
// PORTS
//   clk            in   1       rising-edge clock
//   reset          in   1       synchronous, active-high reset
//   start          in   1       begin fetching from PC 0 (honoured only in IDLE)
//   imem_addr      out  ADDR_W  word index to instruction memory (= current PC)
//   imem_data      in   DATA_W  instruction word at imem_addr, same cycle
//   branch_valid   in   1       redirect request, one-cycle pulse
//   branch_target  in   ADDR_W  new PC when branch_valid=1
//   instr_out      out  DATA_W  registered instruction to decode
//   instr_pc       out  ADDR_W  PC of instr_out
//   instr_valid    out  1       instr_out holds an undelivered instruction
//   instr_ready    in   1       decode accepts; transfer when instr_valid && instr_ready
//   halted         out  1       program finished, all instructions delivered
//   fetch_count    out  CNT_W   number of completed transfers
// BEHAVIOUR
//   Reset (sync, priority over all): state=IDLE, pc=0, instr_out=0, instr_pc=0, instr_valid=0,
//     halted=0, fetch_count=0. Reset mid-operation discards the output stage; no transfer that cycle.
//   imem_addr = pc at all times (combinational from pc register).
//   States: IDLE, FETCH, DRAIN, HALT.
//   IDLE: start=1 -> FETCH (pc stays 0). Other inputs ignored; outputs hold.
//   FETCH: load = (!instr_valid || instr_ready) && pc <= LAST_PC.
//     On load: instr_out<=imem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1 (mod 2^ADDR_W).
//     Read latency: word at pc appears on instr_out the cycle after load.
//     No load because of back-pressure: pc, instr_out, instr_pc, instr_valid hold.
//     Transfer without load: instr_valid<=0.
//     If load and pc==LAST_PC, or pc>LAST_PC: next state DRAIN (no load when pc>LAST_PC).
//   DRAIN: no loads. When instr_valid=0, or a transfer occurs: -> HALT, halted<=1, instr_valid<=0.
//   HALT: all outputs hold; start ignored; exit only by reset.
//   Redirect (branch_valid=1 in FETCH or DRAIN): highest priority after reset.
//     pc<=branch_target, instr_valid<=0 (flush), no load that cycle, state<=FETCH.
//     A transfer occurring in the same cycle still completes and is counted.
//     branch_valid ignored in IDLE and HALT.
//   fetch_count: +1 per transfer, saturates at 2^CNT_W-1 (no wrap).
//   Ready may toggle freely; instr_out/instr_pc are stable while instr_valid && !instr_ready.
// TESTING
//   1 reset, start, ready=1, mem[0..6]=I0..I6 -> instr_out I0..I6 on consecutive cycles, pc 1..7,
//     halted=1 one cycle after I6 transfer, fetch_count=7.
//   2 ready=0 for 3 cycles after I2 becomes valid -> instr_out=I2, instr_pc=2, pc=3 stable;
//     ready=1 -> I3 next cycle, no instruction lost or duplicated.
//   3 branch_valid with target=5 while I1 valid, ready=0 -> I1 flushed (not counted);
//     instr_out=I5, instr_pc=5 one cycle later.
//   4 branch_target=200 (>LAST_PC) -> no load, DRAIN then HALT, instr_valid=0, halted=1.
//   5 reset asserted mid-FETCH with instr_valid=1 -> next cycle all outputs 0, state IDLE;
//     start re-fetches from PC 0.
//   6 CNT_W=2, 7 instructions delivered -> fetch_count saturates at 3; start in HALT -> no effect.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction output stage handshake between fetch and decode
interface fetch_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] instr_out;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output instr_out,
        output instr_pc,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instr_out,
        input  instr_pc,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer with one-entry output stage
module fetch_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LAST_PC = 6,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [ADDR_W-1:0]    imem_addr,
    input  logic [DATA_W-1:0]    imem_data,
    input  logic                 branch_valid,
    input  logic [ADDR_W-1:0]    branch_target,
    fetch_sequencer_if.master    out_if,
    output logic                 halted,
    output logic [CNT_W-1:0]     fetch_count
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_PC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   pc;
    logic [DATA_W-1:0]   instr_out;
    logic [ADDR_W-1:0]   instr_pc;
    logic                instr_valid;
    logic                load;
    logic                xfer;
    logic                redirect;
    logic                to_halt;

    assign imem_addr          = pc;
    assign out_if.instr_out   = instr_out;
    assign out_if.instr_pc    = instr_pc;
    assign out_if.instr_valid = instr_valid;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the per-cycle load / redirect / halt decisions
    always_comb begin
        state_next = state;
        load       = 1'b0;
        redirect   = 1'b0;
        to_halt    = 1'b0;
        xfer       = instr_valid && out_if.instr_ready;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (branch_valid) begin
                    redirect = 1'b1;
                end else begin
                    load = (!instr_valid || out_if.instr_ready) && (pc <= LAST);
                    // Past the end, or just fetched the last word: stop loading
                    if ((pc > LAST) || (load && (pc == LAST))) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (branch_valid) begin
                    redirect   = 1'b1;
                    state_next = FETCH;
                end else if (!instr_valid || xfer) begin
                    to_halt    = 1'b1;
                    state_next = HALT;
                end
            end
            default: begin
                state_next = state;
            end
        endcase
    end

    // PC, output stage, halt flag and saturating transfer counter
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= '0;
            instr_out   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            // A transfer completes even when a redirect flushes the stage
            if (xfer && (fetch_count != {CNT_W{1'b1}})) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end
            if (redirect) begin
                pc          <= branch_target;
                instr_valid <= 1'b0;
            end else if (load) begin
                instr_out   <= imem_data;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
                pc          <= pc + ADDR_W'(1);
            end else if (xfer || to_halt) begin
                instr_valid <= 1'b0;
            end
            if (to_halt) begin
                halted <= 1'b1;
            end
        end
    end
endmodule
